// File: rtl/branch_ctrl_if.sv
// Fetch-loop control bus between the bench/inst_fetch side (master) and branch_ctrl (slave).
interface branch_ctrl_if #(
  parameter int unsigned PC_WIDTH = 12,
  parameter int unsigned LUT_AW   = 4
);
  logic                start;
  logic [PC_WIDTH-1:0] pc;
  logic [2:0]          br_op;
  logic [LUT_AW-1:0]   lut_idx;
  logic                flag_we;
  logic                zero_in;
  logic                carry_in;
  logic                lut_we;
  logic [LUT_AW-1:0]   lut_waddr;
  logic [PC_WIDTH-1:0] lut_wdata;
  logic                branch_en;
  logic [PC_WIDTH-1:0] target;
  logic                done;
  logic                stack_err;

  modport master (
    output start, pc, br_op, lut_idx, flag_we, zero_in, carry_in,
           lut_we, lut_waddr, lut_wdata,
    input  branch_en, target, done, stack_err
  );

  modport slave (
    input  start, pc, br_op, lut_idx, flag_we, zero_in, carry_in,
           lut_we, lut_waddr, lut_wdata,
    output branch_en, target, done, stack_err
  );
endinterface

// File: rtl/branch_ctrl.sv
// Control-flow resolver: flags, target LUT and return stack drive inst_fetch's branch_en/target.
module branch_ctrl #(
  parameter int unsigned PC_WIDTH    = 12,
  parameter int unsigned LUT_AW      = 4,
  parameter int unsigned STACK_DEPTH = 4
) (
  input logic        clk,
  input logic        reset,
  branch_ctrl_if.slave bus
);
  localparam int unsigned LUT_N  = 1 << LUT_AW;
  localparam int unsigned SP_W   = $clog2(STACK_DEPTH + 1);
  localparam int unsigned SIDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_BZ   = 3'd1,
    OP_BNZ  = 3'd2,
    OP_BC   = 3'd3,
    OP_JMP  = 3'd4,
    OP_CALL = 3'd5,
    OP_RET  = 3'd6,
    OP_HALT = 3'd7
  } br_op_e;

  logic [PC_WIDTH-1:0] lut   [LUT_N];
  logic [PC_WIDTH-1:0] stack [STACK_DEPTH];
  logic [SP_W-1:0]     sp;
  logic                z_q;
  logic                c_q;
  logic                done_q;
  logic                err_q;

  logic                br_en;
  logic [PC_WIDTH-1:0] tgt;
  logic                push;
  logic                pop;
  logic                halt;
  logic                stack_full;
  logic                stack_empty;
  logic [SIDX_W-1:0]   top_idx;

  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign top_idx     = SIDX_W'(sp - SP_W'(1));

  // Zero-latency branch decision; reset/start cycles never redirect fetch.
  always_comb begin
    br_en = 1'b0;
    tgt   = lut[bus.lut_idx];
    push  = 1'b0;
    pop   = 1'b0;
    halt  = 1'b0;
    if (reset || bus.start) begin
      br_en = 1'b0;
    end else if (done_q) begin
      br_en = 1'b1;
      tgt   = bus.pc;
    end else begin
      case (br_op_e'(bus.br_op))
        OP_BZ:   br_en = z_q;
        OP_BNZ:  br_en = ~z_q;
        OP_BC:   br_en = c_q;
        OP_JMP:  br_en = 1'b1;
        OP_CALL: begin
          br_en = 1'b1;
          push  = 1'b1;
        end
        OP_RET: begin
          pop = 1'b1;
          if (!stack_empty) begin
            br_en = 1'b1;
            tgt   = stack[top_idx];
          end
        end
        OP_HALT: begin
          br_en = 1'b1;
          tgt   = bus.pc;
          halt  = 1'b1;
        end
        default: br_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      sp     <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      for (int i = 0; i < LUT_N; i++) lut[i] <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else begin
      if (bus.lut_we) lut[bus.lut_waddr] <= bus.lut_wdata;
      if (bus.start) begin
        z_q    <= 1'b0;
        c_q    <= 1'b0;
        sp     <= '0;
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end else if (!done_q) begin
        if (bus.flag_we) begin
          z_q <= bus.zero_in;
          c_q <= bus.carry_in;
        end
        // A full stack still jumps on CALL; only the return address is lost.
        if (push) begin
          if (stack_full) begin
            err_q <= 1'b1;
          end else begin
            stack[SIDX_W'(sp)] <= bus.pc + PC_WIDTH'(1);
            sp                 <= sp + SP_W'(1);
          end
        end
        if (pop) begin
          if (stack_empty) err_q <= 1'b1;
          else             sp    <= sp - SP_W'(1);
        end
        if (halt) done_q <= 1'b1;
      end
    end
  end

  assign bus.branch_en = br_en;
  assign bus.target    = tgt;
  assign bus.done      = done_q;
  assign bus.stack_err = err_q;
endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: jumps, conditionals, call/return stack, halt, LUT and reset.
module tb_branch_ctrl;
  localparam int unsigned PC_WIDTH    = 12;
  localparam int unsigned LUT_AW      = 4;
  localparam int unsigned STACK_DEPTH = 4;

  localparam logic [2:0] NOP = 3'd0, BZ = 3'd1, BNZ = 3'd2, BC = 3'd3,
                         JMP = 3'd4, CALL = 3'd5, RET = 3'd6, HALT = 3'd7;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  branch_ctrl_if #(.PC_WIDTH(PC_WIDTH), .LUT_AW(LUT_AW)) bus ();

  branch_ctrl #(
    .PC_WIDTH   (PC_WIDTH),
    .LUT_AW     (LUT_AW),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic op(input logic [2:0] o, input logic [3:0] idx, input logic [11:0] p);
    bus.br_op   = o;
    bus.lut_idx = idx;
    bus.pc      = p;
  endtask

  task automatic lut_write(input logic [3:0] a, input logic [11:0] d);
    bus.lut_we    = 1'b1;
    bus.lut_waddr = a;
    bus.lut_wdata = d;
    tick();
    bus.lut_we = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    settle();
    chk("start_br_en", 32'(bus.branch_en), 32'd0);
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.flag_we   = 1'b0;
    bus.zero_in   = 1'b0;
    bus.carry_in  = 1'b0;
    bus.lut_we    = 1'b0;
    bus.lut_waddr = '0;
    bus.lut_wdata = '0;
    op(NOP, 4'd0, 12'h000);
    tick();
    tick();
    settle();
    chk("rst_br_en", 32'(bus.branch_en), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.stack_err), 32'd0);
    reset = 1'b0;
    tick();

    // 1: JMP through the LUT
    lut_write(4'd3, 12'h040);
    lut_write(4'd1, 12'h020);
    lut_write(4'd2, 12'h100);
    lut_write(4'd5, 12'h011);
    op(JMP, 4'd3, 12'h010);
    settle();
    chk("jmp_en", 32'(bus.branch_en), 32'd1);
    chk("jmp_tgt", 32'(bus.target), 32'h040);
    tick();

    // 2: conditionals read registered flags
    op(NOP, 4'd0, 12'h011);
    bus.flag_we = 1'b1; bus.zero_in = 1'b1; bus.carry_in = 1'b0;
    tick();
    bus.flag_we = 1'b0;
    op(BZ, 4'd1, 12'h012);
    settle();
    chk("bz_taken_en", 32'(bus.branch_en), 32'd1);
    chk("bz_taken_tgt", 32'(bus.target), 32'h020);
    tick();
    op(BNZ, 4'd1, 12'h013);
    settle();
    chk("bnz_nt_en", 32'(bus.branch_en), 32'd0);
    tick();
    op(BC, 4'd1, 12'h014);
    settle();
    chk("bc_nt_en", 32'(bus.branch_en), 32'd0);
    tick();
    op(NOP, 4'd0, 12'h015);
    bus.flag_we = 1'b1; bus.zero_in = 1'b0; bus.carry_in = 1'b1;
    tick();
    op(BZ, 4'd1, 12'h016);
    bus.zero_in = 1'b1;
    settle();
    chk("bz_same_cycle_flag", 32'(bus.branch_en), 32'd0);
    chk("bz_nt_tgt", 32'(bus.target), 32'h020);
    tick();
    bus.flag_we = 1'b0;
    op(BC, 4'd3, 12'h017);
    settle();
    chk("bc_taken_en", 32'(bus.branch_en), 32'd1);
    chk("bc_taken_tgt", 32'(bus.target), 32'h040);
    tick();
    op(BZ, 4'd1, 12'h018);
    settle();
    chk("bz_after_update", 32'(bus.branch_en), 32'd1);
    tick();

    // 3: single CALL/RET
    op(CALL, 4'd2, 12'h00A);
    settle();
    chk("call_en", 32'(bus.branch_en), 32'd1);
    chk("call_tgt", 32'(bus.target), 32'h100);
    tick();
    op(RET, 4'd0, 12'h100);
    settle();
    chk("ret_en", 32'(bus.branch_en), 32'd1);
    chk("ret_tgt", 32'(bus.target), 32'h00B);
    tick();
    settle();
    chk("ret_err", 32'(bus.stack_err), 32'd0);
    op(RET, 4'd0, 12'h00B);
    settle();
    chk("underflow_en", 32'(bus.branch_en), 32'd0);
    tick();
    op(NOP, 4'd0, 12'h00C);
    settle();
    chk("underflow_err", 32'(bus.stack_err), 32'd1);
    do_start();
    settle();
    chk("start_clr_err", 32'(bus.stack_err), 32'd0);

    // 4: nested calls past the stack depth
    for (int i = 0; i < 5; i++) begin
      op(CALL, 4'd2, 12'(12'h200 + 12'(i * 16)));
      settle();
      chk("ncall_en", 32'(bus.branch_en), 32'd1);
      chk("ncall_tgt", 32'(bus.target), 32'h100);
      chk("ncall_err_pre", 32'(bus.stack_err), 32'd0);
      tick();
    end
    op(NOP, 4'd0, 12'h100);
    settle();
    chk("overflow_err", 32'(bus.stack_err), 32'd1);
    for (int i = 3; i >= 0; i--) begin
      op(RET, 4'd0, 12'h100);
      settle();
      chk("nret_en", 32'(bus.branch_en), 32'd1);
      chk("nret_tgt", 32'(bus.target), 32'(12'h201 + 12'(i * 16)));
      tick();
    end
    op(RET, 4'd0, 12'h100);
    settle();
    chk("nret5_en", 32'(bus.branch_en), 32'd0);
    tick();
    do_start();

    // 5: HALT holds pc regardless of op
    op(HALT, 4'd0, 12'h055);
    settle();
    chk("halt_en", 32'(bus.branch_en), 32'd1);
    chk("halt_tgt", 32'(bus.target), 32'h055);
    chk("halt_done_pre", 32'(bus.done), 32'd0);
    tick();
    settle();
    chk("halt_done", 32'(bus.done), 32'd1);
    for (int i = 0; i < 10; i++) begin
      op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 12'h055);
      settle();
      chk("done_hold_en", 32'(bus.branch_en), 32'd1);
      chk("done_hold_tgt", 32'(bus.target), 32'h055);
      tick();
    end
    op(NOP, 4'd0, 12'h055);
    do_start();
    settle();
    chk("start_clr_done", 32'(bus.done), 32'd0);
    op(JMP, 4'd3, 12'h056);
    settle();
    chk("lut_kept", 32'(bus.target), 32'h040);
    tick();

    // 6: write-while-read returns the old LUT value
    op(JMP, 4'd5, 12'h060);
    bus.lut_we = 1'b1; bus.lut_waddr = 4'd5; bus.lut_wdata = 12'h0AA;
    settle();
    chk("lut_old", 32'(bus.target), 32'h011);
    tick();
    bus.lut_we = 1'b0;
    settle();
    chk("lut_new", 32'(bus.target), 32'h0AA);
    tick();

    // Reset in the middle of a CALL wipes flags, stack and LUT
    op(NOP, 4'd0, 12'h2FF);
    bus.flag_we = 1'b1; bus.zero_in = 1'b1; bus.carry_in = 1'b1;
    tick();
    bus.flag_we = 1'b0;
    op(CALL, 4'd2, 12'h300);
    reset = 1'b1;
    settle();
    chk("rst_call_en", 32'(bus.branch_en), 32'd0);
    tick();
    reset = 1'b0;
    op(BZ, 4'd1, 12'h000);
    settle();
    chk("rst_z_clear", 32'(bus.branch_en), 32'd0);
    op(BC, 4'd1, 12'h000);
    settle();
    chk("rst_c_clear", 32'(bus.branch_en), 32'd0);
    op(RET, 4'd0, 12'h000);
    settle();
    chk("rst_sp_zero", 32'(bus.branch_en), 32'd0);
    op(NOP, 4'd0, 12'h000);
    for (int i = 0; i < 16; i++) begin
      op(JMP, 4'(i), 12'h000);
      #1;
      chk("rst_lut_zero", 32'(bus.target), 32'd0);
    end
    chk("rst_done2", 32'(bus.done), 32'd0);
    chk("rst_err2", 32'(bus.stack_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
